// File: rtl/pwr_seq_ctrl_n.sv
// pwr_seq_ctrl_n: panel power-sequence controller for N supply rails.
//
// Power-up order: rail_en[0] .. rail_en[N-1], one rail every STEP_CYCLES.
// Then lcd_rst is released after RST_CYCLES, and hs_start/pwr_good rise
// after HS_CYCLES. When pwr_req drops, lcd_rst/hs_start/pwr_good fall on
// the next edge and the rails are disabled in reverse order, one every
// STEP_CYCLES, starting from the highest enabled rail. pwr_req is a level:
// it is ignored while powering down, and a new power-up starts from OFF.
//
// Optional feature macro: PWR_SEQ_PG_CHECK_EN
//   Defined   : per-rail power-good supervision. A rail's pg_in is checked
//               from the first clock after its step window onwards (all
//               rails in RST_HOLD/HS_WAIT/ON). A low pg_in enters FAULT:
//               every output drops and fault=1 until pwr_req goes low.
//   Undefined : pg_in is ignored and fault is tied low.
//
// Ports:
//   clk      in   reference clock (12 MHz)
//   reset    in   synchronous active-high reset
//   pwr_req  in   1 = power the panel up, 0 = power it down
//   pg_in    in   per-rail power-good (only used with PWR_SEQ_PG_CHECK_EN)
//   rail_en  out  per-rail supply enables, 1 = rail on
//   lcd_rst  out  panel reset, active low
//   hs_start out  panel ready, HS/PLL path may run
//   pwr_good out  sequence complete (state ON)
//   busy     out  sequencing up or down
//   fault    out  sticky power-good fault
module pwr_seq_ctrl_n #(
  parameter int NUM_RAILS   = 3,
  parameter int STEP_CYCLES = 120000,
  parameter int RST_CYCLES  = 60000,
  parameter int HS_CYCLES   = 12000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwr_req,
  input  logic [NUM_RAILS-1:0] pg_in,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 lcd_rst,
  output logic                 hs_start,
  output logic                 pwr_good,
  output logic                 busy,
  output logic                 fault
);

  localparam int MAX_SR = (STEP_CYCLES > RST_CYCLES) ? STEP_CYCLES : RST_CYCLES;
  localparam int MAX_C  = (MAX_SR > HS_CYCLES) ? MAX_SR : HS_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

  // Windows are counted load..0, so the load value is the length minus one.
  localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] HS_LOAD   = CW'(HS_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RAILS - 1);

  typedef enum logic [2:0] {
    S_OFF, S_UP, S_RST_HOLD, S_HS_WAIT, S_ON, S_DOWN, S_FAULT
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        idx_reg, idx_next;   // highest rail currently enabled
  logic                 pg_bad;

  logic [NUM_RAILS-1:0] rail_mask;
  logic [NUM_RAILS-1:0] rail_en_next;
  logic                 lcd_rst_next, hs_start_next, pwr_good_next, busy_next, fault_next;

`ifdef PWR_SEQ_PG_CHECK_EN
  logic [NUM_RAILS-1:0] pg_chk;
  // During UP only rails whose step window has finished are supervised.
  generate
    for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_pg_chk
      assign pg_chk[gi] = (state_reg == S_UP) ? (idx_reg > IW'(gi))
                        : (state_reg inside {S_RST_HOLD, S_HS_WAIT, S_ON});
    end
  endgenerate
  assign pg_bad = |(pg_chk & ~pg_in);
`else
  logic pg_unused;
  assign pg_unused = ^pg_in;
  assign pg_bad    = 1'b0;
`endif

  // State, counter, index and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_OFF;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rail_en   <= '0;
      lcd_rst   <= 1'b0;
      hs_start  <= 1'b0;
      pwr_good  <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rail_en   <= rail_en_next;
      lcd_rst   <= lcd_rst_next;
      hs_start  <= hs_start_next;
      pwr_good  <= pwr_good_next;
      busy      <= busy_next;
      fault     <= fault_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - CW'(1) : cnt_reg;
    case (state_reg)
      S_OFF: begin
        if (pwr_req) begin
          state_next = S_UP;
          idx_next   = '0;
          cnt_next   = STEP_LOAD;
        end
      end
      S_UP, S_RST_HOLD, S_HS_WAIT, S_ON: begin
        if (pg_bad) begin
          state_next = S_FAULT;
          idx_next   = '0;
          cnt_next   = '0;
        end else if (!pwr_req) begin
          // Shutdown starts from the current (highest enabled) rail.
          state_next = S_DOWN;
          cnt_next   = STEP_LOAD;
        end else if (cnt_reg == '0) begin
          if (state_reg == S_UP) begin
            if (idx_reg == LAST_IDX) begin
              state_next = S_RST_HOLD;
              cnt_next   = RST_LOAD;
            end else begin
              idx_next = idx_reg + IW'(1);
              cnt_next = STEP_LOAD;
            end
          end else if (state_reg == S_RST_HOLD) begin
            state_next = S_HS_WAIT;
            cnt_next   = HS_LOAD;
          end else if (state_reg == S_HS_WAIT) begin
            state_next = S_ON;
          end
        end
      end
      S_DOWN: begin
        if (cnt_reg == '0) begin
          if (idx_reg == '0) begin
            state_next = S_OFF;
          end else begin
            idx_next = idx_reg - IW'(1);
            cnt_next = STEP_LOAD;
          end
        end
      end
      S_FAULT: begin
        if (!pwr_req) begin
          state_next = S_OFF;
        end
      end
      default: begin
        state_next = S_OFF;
        idx_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Rails 0..idx are on whenever a sequence is in progress or complete.
  generate
    for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_rail_mask
      assign rail_mask[gi] = (idx_next >= IW'(gi));
    end
  endgenerate

  // Output logic: computed from the next state so outputs update with it.
  always_comb begin
    rail_en_next  = '0;
    lcd_rst_next  = 1'b0;
    hs_start_next = 1'b0;
    pwr_good_next = 1'b0;
    busy_next     = 1'b0;
    if (state_next inside {S_UP, S_RST_HOLD, S_HS_WAIT, S_ON, S_DOWN}) begin
      rail_en_next = rail_mask;
    end
    if (state_next inside {S_HS_WAIT, S_ON}) begin
      lcd_rst_next = 1'b1;
    end
    if (state_next == S_ON) begin
      hs_start_next = 1'b1;
      pwr_good_next = 1'b1;
    end
    if (state_next inside {S_UP, S_RST_HOLD, S_HS_WAIT, S_DOWN}) begin
      busy_next = 1'b1;
    end
`ifdef PWR_SEQ_PG_CHECK_EN
    fault_next = (state_next == S_FAULT);
`else
    fault_next = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pwr_seq_ctrl_n.sv
module tb_pwr_seq_ctrl_n;
  localparam int N = 2;
  localparam int S = 4;
  localparam int R = 3;
  localparam int H = 2;
  localparam int OW = N + 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwr_req = 1'b0;
  logic [N-1:0] pg_in = '1;
  logic [N-1:0] rail_en;
  logic         lcd_rst, hs_start, pwr_good, busy, fault;

  int checks = 0;
  int failures = 0;
  int now = 0;

  // Reference model: timeline of the current sequence, not a state machine copy.
  typedef enum {M_OFF, M_UP, M_DOWN, M_FAULT} mode_t;
  mode_t mode = M_OFF;
  int up_start = 0;    // first cycle with rail 0 on
  int down_start = 0;  // first cycle of the shutdown
  int top_rail = 0;    // highest rail on when shutdown began

  pwr_seq_ctrl_n #(
    .NUM_RAILS(N), .STEP_CYCLES(S), .RST_CYCLES(R), .HS_CYCLES(H)
  ) dut (
    .clk(clk), .reset(reset), .pwr_req(pwr_req), .pg_in(pg_in),
    .rail_en(rail_en), .lcd_rst(lcd_rst), .hs_start(hs_start),
    .pwr_good(pwr_good), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the inputs held during the previous cycle.
  task automatic model_edge(input logic r, input logic rs, input logic [N-1:0] pg);
    int e;
    int nchk;
    logic bad;
    if (rs) begin
      mode = M_OFF;
      return;
    end
    case (mode)
      M_OFF: if (r) begin mode = M_UP; up_start = now; end
      M_UP: begin
        e = now - 1 - up_start;
        nchk = e / S;
        if (nchk > N) nchk = N;
        bad = 1'b0;
        for (int j = 0; j < nchk; j++) if (!pg[j]) bad = 1'b1;
`ifdef PWR_SEQ_PG_CHECK_EN
        if (bad) mode = M_FAULT;
        else
`endif
        if (!r) begin
          mode = M_DOWN;
          down_start = now;
          top_rail = e / S;
          if (top_rail > N - 1) top_rail = N - 1;
        end
      end
      M_DOWN: if (now - down_start >= (top_rail + 1) * S) mode = M_OFF;
      M_FAULT: if (!r) mode = M_OFF;
      default: mode = M_OFF;
    endcase
  endtask

  function automatic logic [OW-1:0] expected();
    logic [N-1:0] rails;
    logic lcd, hs, pgood, bsy, flt;
    int e;
    int nr;
    rails = '0; lcd = 0; hs = 0; pgood = 0; bsy = 0; flt = 0;
    case (mode)
      M_UP: begin
        e = now - up_start;
        nr = (e < N * S) ? e / S + 1 : N;
        for (int j = 0; j < N; j++) rails[j] = (j < nr);
        lcd = (e >= N * S + R);
        hs = (e >= N * S + R + H);
        pgood = hs;
        bsy = !hs;
      end
      M_DOWN: begin
        e = now - down_start;
        for (int j = 0; j < N; j++) rails[j] = (j <= top_rail) && (e < (top_rail - j + 1) * S);
        bsy = 1'b1;
      end
      M_FAULT: flt = 1'b1;
      default: ;
    endcase
    return {rails, lcd, hs, pgood, bsy, flt};
  endfunction

  task automatic tick(input string tag);
    logic [OW-1:0] obs;
    logic [OW-1:0] exp;
    @(posedge clk);
    now++;
    model_edge(pwr_req, reset, pg_in);
    #1;
    exp = expected();
    obs = {rail_en, lcd_rst, hs_start, pwr_good, busy, fault};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, now, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask

  initial begin
    int hold;
    hold = 0;

    // Reset state
    repeat (3) tick("reset");
    chk("reset_rails", 32'(rail_en), 0);
    reset = 1'b0;
    repeat (2) tick("idle");
    $display("phase reset/idle done at cycle %0d", now);

    // Power-up: request seen in cycle c
    pwr_req = 1'b1;
    tick("up");
    chk("up_rail0", 32'(rail_en), 1);
    repeat (4) tick("up");
    chk("up_rail1", 32'(rail_en), 3);
    repeat (7) tick("up");
    chk("up_lcd_rst", 32'(lcd_rst), 1);
    repeat (2) tick("up");
    chk("up_hs_start", 32'({hs_start, pwr_good, busy}), 3'b110);
    repeat (3) tick("on");
    $display("phase power-up done at cycle %0d", now);

    // Power-down from ON
    pwr_req = 1'b0;
    tick("down");
    chk("down_lcd", 32'({lcd_rst, hs_start, pwr_good, busy}), 4'b0001);
    repeat (4) tick("down");
    chk("down_rail1", 32'(rail_en), 1);
    repeat (4) tick("down");
    chk("down_rail0", 32'({rail_en, busy}), 0);
    repeat (2) tick("off");
    $display("phase power-down done at cycle %0d", now);

    // Abort while only rail 0 is on; re-request during shutdown is ignored
    pwr_req = 1'b1;
    repeat (3) tick("abort");
    pwr_req = 1'b0;
    tick("abort");
    pwr_req = 1'b1;
    repeat (3) tick("abort");
    chk("abort_hold", 32'({rail_en, busy}), 3'b011);
    tick("abort");
    chk("abort_off", 32'({rail_en, busy}), 0);
    tick("restart");
    chk("restart_rail0", 32'(rail_en), 1);
    $display("phase abort done at cycle %0d", now);

    // Reset while in RST_HOLD, request still high
    repeat (9) tick("rst_hold");
    reset = 1'b1;
    tick("mid_reset");
    chk("mid_reset_out", 32'({rail_en, lcd_rst, busy}), 0);
    reset = 1'b0;
    tick("after_reset");
    chk("after_reset_rail0", 32'(rail_en), 1);
    repeat (20) tick("after_reset");
    pwr_req = 1'b0;
    repeat (12) tick("after_reset");
    $display("phase mid-sequence reset done at cycle %0d", now);

`ifdef PWR_SEQ_PG_CHECK_EN
    // Rail 1 never reports power-good
    pg_in = 2'b01;
    pwr_req = 1'b1;
    repeat (10) tick("pg_fault");
    chk("pg_fault_set", 32'({rail_en, fault}), 1);
    pwr_req = 1'b0;
    tick("pg_fault_clr");
    chk("pg_fault_clr", 32'(fault), 0);
    // Rail 0 glitches low while ON
    pg_in = 2'b11;
    pwr_req = 1'b1;
    repeat (16) tick("pg_on");
    pg_in = 2'b10;
    tick("pg_on");
    pg_in = 2'b11;
    tick("pg_on_fault");
    chk("pg_on_fault", 32'({rail_en, hs_start, fault}), 1);
    pwr_req = 1'b0;
    repeat (2) tick("pg_on_fault");
    $display("phase power-good supervision done at cycle %0d", now);
`endif

    // Randomized level requests, occasional reset and power-good noise
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        pwr_req = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 30);
      end
      hold--;
      reset = ($urandom_range(0, 99) == 0);
`ifdef PWR_SEQ_PG_CHECK_EN
      pg_in = ($urandom_range(0, 39) == 0) ? N'($urandom) : '1;
`else
      pg_in = N'($urandom);
`endif
      tick("random");
    end
    $display("phase random done at cycle %0d", now);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
